// File: rtl/sdpram_bus_port_if.sv
// rtl/sdpram_bus_port_if.sv - request/response handshake bundle for sdpram_bus_port
//
// Purpose: groups the valid/ready load/store request channel and the in-order
// response channel between a core bus master and the RAM front end.
// Signals:
//   req_valid/req_ready  request handshake (fire when both high)
//   req_we               1 = store, 0 = load
//   req_addr  [AW]       byte address
//   req_wdata [DW]       store data
//   rsp_valid/rsp_ready  response handshake (consumed when both high)
//   rsp_data  [DW]       load data, 0 for stores and errors
//   rsp_err              misaligned or out-of-range request
// Modports: master = requester (CPU side), slave = sdpram_bus_port.

interface sdpram_bus_port_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/sdpram_bus_port.sv
// rtl/sdpram_bus_port.sv - requester-side front end for a simple dual-port RAM
//
// Purpose: turns a valid/ready byte-addressed load/store request stream into
// RAM port A writes and port B reads, and returns exactly one response per
// accepted request, in acceptance order, through a small response FIFO.
// Ports:
//   clk           clock
//   rst           asynchronous reset, active-high (same net as the RAM reset)
//   bus           request/response bundle (slave side)
//   mem_we_a      RAM write enable
//   mem_addr_a    RAM write word index, zero-extended
//   mem_w_data_a  RAM write data
//   mem_re_b      RAM read enable
//   mem_addr_b    RAM read word index, zero-extended
//   mem_r_data_b  RAM read data, valid the cycle after mem_re_b

module sdpram_bus_port #(
  parameter int AddrBusWidth = 32,
  parameter int DataBusWidth = 32,
  parameter int MemSizeBytes = 1024,
  parameter int RspDepth     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  sdpram_bus_port_if.slave        bus,
  output logic                    mem_we_a,
  output logic [AddrBusWidth-1:0] mem_addr_a,
  output logic [DataBusWidth-1:0] mem_w_data_a,
  output logic                    mem_re_b,
  output logic [AddrBusWidth-1:0] mem_addr_b,
  input  logic [DataBusWidth-1:0] mem_r_data_b
);

  localparam int WordSizeBits = $clog2(DataBusWidth / 8);
  localparam int MemSizeWords = MemSizeBytes / (DataBusWidth / 8);
  localparam int PtrW         = $clog2(RspDepth);
  localparam int CntW         = PtrW + 1;

  localparam logic [AddrBusWidth-1:0] LowMask   = AddrBusWidth'((1 << WordSizeBits) - 1);
  localparam logic [AddrBusWidth-1:0] WordLimit = AddrBusWidth'(MemSizeWords);
  localparam logic [CntW:0]           DepthCnt  = (CntW + 1)'(RspDepth);

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [AddrBusWidth-1:0] word_idx;
  logic                    misaligned;
  logic                    out_of_range;
  logic                    req_err;
  logic                    fire;

  assign word_idx     = bus.req_addr >> WordSizeBits;
  assign misaligned   = (bus.req_addr & LowMask) != '0;
  assign out_of_range = word_idx >= WordLimit;
  assign req_err      = misaligned || out_of_range;
  assign fire         = bus.req_valid && bus.req_ready;

  // ---------------------------------------------------------------------------
  // Pending stage: one slot between RAM read issue and FIFO push, matching the
  // one-cycle read latency of port B.
  // ---------------------------------------------------------------------------
  logic pend_valid;
  logic pend_load;
  logic pend_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_load  <= 1'b0;
      pend_err   <= 1'b0;
    end else begin
      pend_valid <= fire;
      pend_load  <= !bus.req_we;
      pend_err   <= req_err;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  logic [DataBusWidth-1:0] fifo_data [RspDepth];
  logic                    fifo_err  [RspDepth];
  logic [PtrW-1:0]         wr_ptr;
  logic [PtrW-1:0]         rd_ptr;
  logic [CntW-1:0]         count;
  logic                    push;
  logic                    pop;
  logic                    rsp_valid_int;
  logic [DataBusWidth-1:0] push_data;

  assign rsp_valid_int = count != '0;
  // The credit rule reserves a slot for every pending entry, so push never
  // finds the FIFO full.
  assign push      = pend_valid;
  assign pop       = rsp_valid_int && bus.rsp_ready;
  assign push_data = (pend_load && !pend_err) ? mem_r_data_b : '0;

  // Storage needs no reset: entries are only observed through the valid gate.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= push_data;
      fifo_err[wr_ptr]  <= pend_err;
    end
  end

  // Pointers are exactly PtrW bits wide, so they wrap modulo RspDepth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Credit: a request is only accepted if a FIFO slot is guaranteed for its
  // response, counting the one still in the pending stage. Built from
  // registered state only, so rsp_ready never reaches req_ready.
  // ---------------------------------------------------------------------------
  logic [CntW:0] occupancy;

  assign occupancy     = {1'b0, count} + {{CntW{1'b0}}, pend_valid};
  assign bus.req_ready = !rst && (occupancy < DepthCnt);

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rsp_valid = rsp_valid_int;
  assign bus.rsp_data  = rsp_valid_int ? fifo_data[rd_ptr] : '0;
  assign bus.rsp_err   = rsp_valid_int && fifo_err[rd_ptr];

  // req_ready already folds in rst, so fire is low throughout reset.
  assign mem_we_a     = fire && bus.req_we && !req_err;
  assign mem_addr_a   = word_idx;
  assign mem_w_data_a = bus.req_wdata;
  assign mem_re_b     = fire && !bus.req_we && !req_err;
  assign mem_addr_b   = word_idx;

endmodule
